reg_file: RTL and testbench

- Architectural integer register file (x0..x31) with a pending-write scoreboard.
- Sits between the decode stage (read ports, issue/scoreboard set) and the write-back stage, which drives the rf_wen/rf_waddr/rf_wdata write port.
- Also receives a retire strobe from write-back.
- Decode uses the two read ports plus per-source busy flags to decide stalls.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_if.sv | 46 ++++
 rtl/reg_file_sb_counter.sv | 46 ++++
 rtl/reg_file.sv | 109 ++++++++++
 tb/tb_reg_file.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and types for the integer register file
//
// Purpose : common constants (XLEN, register address width, register count)
//           and the data/address types used by the register file slice.
// Ports   : none (package).

package reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - decode/write-back bundle for the register file
//
// Purpose : groups the read ports, write-back port, scoreboard set/clear
//           strobes and the sticky scoreboard error flags.
// Modports: master - decode/write-back side (drives addresses, writes, strobes)
//           slave  - register file side (drives read data, busy, error flags)

interface reg_file_if;
  import reg_file_pkg::*;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  xlen_t     rs1_data;
  xlen_t     rs2_data;
  logic      rs1_busy;
  logic      rs2_busy;

  logic      rf_wen;
  reg_addr_t rf_waddr;
  xlen_t     rf_wdata;

  logic      sb_set;
  reg_addr_t sb_set_rd;
  logic      sb_clr;
  reg_addr_t sb_clr_rd;

  logic      sb_overflow;
  logic      sb_underflow;

  modport master (
    output rs1_addr, rs2_addr,
    output rf_wen, rf_waddr, rf_wdata,
    output sb_set, sb_set_rd, sb_clr, sb_clr_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy,
    input  sb_overflow, sb_underflow
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  rf_wen, rf_waddr, rf_wdata,
    input  sb_set, sb_set_rd, sb_clr, sb_clr_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy,
    output sb_overflow, sb_underflow
  );

endinterface

// File: rtl/reg_file_sb_counter.sv
// rtl/reg_file_sb_counter.sv - saturating pending-write counter for one register
//
// Purpose : counts in-flight writes to a single architectural register.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           set          - an instruction writing this register was issued
//           clr          - an instruction writing this register retired
//           cnt          - current number of in-flight writes
//           ovf / unf    - single-cycle pulses: set at max / clr at zero

module reg_file_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_nxt;

  // Simultaneous set and clr cancel: one issue and one retire leave the
  // in-flight count unchanged, even at the saturation limits.
  always_comb begin
    cnt_nxt = cnt;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (set && !clr) begin
      if (cnt == CNT_MAX) ovf = 1'b1;
      else                cnt_nxt = cnt + 1'b1;
    end else if (clr && !set) begin
      if (cnt == '0) unf = 1'b1;
      else           cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - x0..x31 register file with pending-write scoreboard
//
// Purpose : two combinational read ports, one write-back port, per-register
//           pending-write counters driving per-source busy flags, and sticky
//           overflow/underflow error flags.
// Ports   : clk, rst_n - core clock, asynchronous active-low reset
//           rf         - reg_file_if.slave (read ports, write port,
//                        scoreboard set/clear, busy and error flags)
// Params  : BYPASS - forward same-cycle write data to reads and busy
//           CNT_W  - width of each pending-write counter

module reg_file
  import reg_file_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_if.slave    rf
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // x0 has no storage; reads of address 0 are forced to zero below.
  xlen_t            regs    [1:NUM_REGS-1];
  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [NUM_REGS-1:1] ovf_vec;
  logic [NUM_REGS-1:1] unf_vec;
  logic             overflow_q;
  logic             underflow_q;

  // Data array: the write-back port already filters x0, but it is
  // rejected here as well so a stray write can never corrupt reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rf.rf_wen && (rf.rf_waddr != '0)) begin
      regs[rf.rf_waddr] <= rf.rf_wdata;
    end
  end

  // Scoreboard: one counter per writable register; x0 is permanently idle,
  // so set/clr aimed at x0 never reach a counter and cannot raise errors.
  assign cnt[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
    logic set_hit;
    logic clr_hit;

    assign set_hit = rf.sb_set && (rf.sb_set_rd == REG_ADDR_W'(g));
    assign clr_hit = rf.sb_clr && (rf.sb_clr_rd == REG_ADDR_W'(g));

    reg_file_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (set_hit),
      .clr   (clr_hit),
      .cnt   (cnt[g]),
      .ovf   (ovf_vec[g]),
      .unf   (unf_vec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (|ovf_vec);
      underflow_q <= underflow_q | (|unf_vec);
    end
  end

  assign rf.sb_overflow  = overflow_q;
  assign rf.sb_underflow = underflow_q;

  function automatic xlen_t read_val(input reg_addr_t addr, input xlen_t arr_val,
                                     input logic wen, input reg_addr_t waddr,
                                     input xlen_t wdata);
    if (addr == '0)                        return '0;
    if (BYPASS && wen && (waddr == addr))  return wdata;
    return arr_val;
  endfunction

  // Busy is suppressed when the last in-flight write to the source retires
  // this very cycle with its data on the write port, because that data is
  // already being forwarded. A same-cycle issue to the source deliberately
  // does not count: the issuing instruction reads its sources first.
  function automatic logic busy_val(input reg_addr_t addr, input logic [CNT_W-1:0] c,
                                    input logic clr, input reg_addr_t clr_rd,
                                    input logic wen, input reg_addr_t waddr);
    if (c == '0) return 1'b0;
    if (BYPASS && clr && (clr_rd == addr) && (c == CNT_ONE) && wen && (waddr == addr))
      return 1'b0;
    return 1'b1;
  endfunction

  assign rf.rs1_data = read_val(rf.rs1_addr, regs[rf.rs1_addr], rf.rf_wen,
                                rf.rf_waddr, rf.rf_wdata);
  assign rf.rs2_data = read_val(rf.rs2_addr, regs[rf.rs2_addr], rf.rf_wen,
                                rf.rf_waddr, rf.rf_wdata);

  assign rf.rs1_busy = busy_val(rf.rs1_addr, cnt[rf.rs1_addr], rf.sb_clr,
                                rf.sb_clr_rd, rf.rf_wen, rf.rf_waddr);
  assign rf.rs2_busy = busy_val(rf.rs2_addr, cnt[rf.rs2_addr], rf.sb_clr,
                                rf.sb_clr_rd, rf.rf_wen, rf.rf_waddr);

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard testbench for reg_file

module tb_reg_file;
  import reg_file_pkg::*;

  localparam int SEL_RS1_DATA = 0;
  localparam int SEL_RS2_DATA = 1;
  localparam int SEL_RS1_BUSY = 2;
  localparam int SEL_RS2_BUSY = 3;
  localparam int SEL_OVF      = 4;
  localparam int SEL_UNF      = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  reg_file_if rf_bus ();

  reg_file #(.BYPASS(1'b1), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // Monitor: outputs are combinational and settled by the falling edge, so
  // every expectation queued during the current cycle is checked there.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RS1_DATA: act = rf_bus.rs1_data;
        SEL_RS2_DATA: act = rf_bus.rs2_data;
        SEL_RS1_BUSY: act = {31'b0, rf_bus.rs1_busy};
        SEL_RS2_BUSY: act = {31'b0, rf_bus.rs2_busy};
        SEL_OVF:      act = {31'b0, rf_bus.sb_overflow};
        default:      act = {31'b0, rf_bus.sb_underflow};
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h required %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_out(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_flags(input string n, input logic ovf, input logic unf);
    expect_out({n, "_ovf"}, SEL_OVF, {31'b0, ovf});
    expect_out({n, "_unf"}, SEL_UNF, {31'b0, unf});
  endtask

  // Advance to just after the next rising edge and return strobes to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    rf_bus.rf_wen = 1'b0;
    rf_bus.sb_set = 1'b0;
    rf_bus.sb_clr = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rf_bus.rs1_addr  = '0;
    rf_bus.rs2_addr  = '0;
    rf_bus.rf_wen    = 1'b0;
    rf_bus.rf_waddr  = '0;
    rf_bus.rf_wdata  = '0;
    rf_bus.sb_set    = 1'b0;
    rf_bus.sb_set_rd = '0;
    rf_bus.sb_clr    = 1'b0;
    rf_bus.sb_clr_rd = '0;

    // 1. reset values
    cyc();
    rf_bus.rs1_addr = 5'd1;
    expect_out("rst_rs1_data", SEL_RS1_DATA, 32'h0);
    expect_flags("rst", 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      cyc();
      rf_bus.rs1_addr = 5'(i);
      rf_bus.rs2_addr = 5'(32 - i);
      expect_out("init_rs1_data", SEL_RS1_DATA, 32'h0);
      expect_out("init_rs2_data", SEL_RS2_DATA, 32'h0);
      expect_out("init_rs1_busy", SEL_RS1_BUSY, 32'h0);
      expect_out("init_rs2_busy", SEL_RS2_BUSY, 32'h0);
    end
    expect_flags("init", 1'b0, 1'b0);

    // 2. write x5 with same-cycle bypass, then array read
    cyc();
    rf_bus.rs1_addr = 5'd5;
    rf_bus.rf_wen   = 1'b1;
    rf_bus.rf_waddr = 5'd5;
    rf_bus.rf_wdata = 32'hDEADBEEF;
    expect_out("bypass_x5", SEL_RS1_DATA, 32'hDEADBEEF);
    cyc();
    expect_out("array_x5", SEL_RS1_DATA, 32'hDEADBEEF);

    // 3. write to x0 is ignored
    cyc();
    rf_bus.rs2_addr = 5'd0;
    rf_bus.rf_wen   = 1'b1;
    rf_bus.rf_waddr = 5'd0;
    rf_bus.rf_wdata = 32'h1234;
    expect_out("x0_same_cycle", SEL_RS2_DATA, 32'h0);
    expect_out("x0_busy", SEL_RS2_BUSY, 32'h0);
    cyc();
    expect_out("x0_next_cycle", SEL_RS2_DATA, 32'h0);
    expect_out("x5_kept", SEL_RS1_DATA, 32'hDEADBEEF);

    // 4. two pending writes to x7, retire with forwarding
    cyc();
    rf_bus.rs1_addr  = 5'd7;
    rf_bus.sb_set    = 1'b1;
    rf_bus.sb_set_rd = 5'd7;
    expect_out("x7_set_same_cycle", SEL_RS1_BUSY, 32'h0);
    expect_out("x7_data0", SEL_RS1_DATA, 32'h0);
    cyc();
    rf_bus.sb_set    = 1'b1;
    rf_bus.sb_set_rd = 5'd7;
    expect_out("x7_busy_cnt1", SEL_RS1_BUSY, 32'h1);
    cyc();
    expect_out("x7_busy_cnt2", SEL_RS1_BUSY, 32'h1);
    cyc();
    rf_bus.sb_clr    = 1'b1;
    rf_bus.sb_clr_rd = 5'd7;
    expect_out("x7_first_clr", SEL_RS1_BUSY, 32'h1);
    cyc();
    rf_bus.sb_clr    = 1'b1;
    rf_bus.sb_clr_rd = 5'd7;
    rf_bus.rf_wen    = 1'b1;
    rf_bus.rf_waddr  = 5'd7;
    rf_bus.rf_wdata  = 32'h55;
    expect_out("x7_last_clr_busy", SEL_RS1_BUSY, 32'h0);
    expect_out("x7_last_clr_data", SEL_RS1_DATA, 32'h55);
    cyc();
    expect_out("x7_idle_busy", SEL_RS1_BUSY, 32'h0);
    expect_out("x7_idle_data", SEL_RS1_DATA, 32'h55);

    // 5. set and clr to x3 together with cnt=1
    cyc();
    rf_bus.rs2_addr  = 5'd3;
    rf_bus.sb_set    = 1'b1;
    rf_bus.sb_set_rd = 5'd3;
    expect_out("x3_set", SEL_RS2_BUSY, 32'h0);
    cyc();
    rf_bus.sb_set    = 1'b1;
    rf_bus.sb_set_rd = 5'd3;
    rf_bus.sb_clr    = 1'b1;
    rf_bus.sb_clr_rd = 5'd3;
    expect_out("x3_set_clr", SEL_RS2_BUSY, 32'h1);
    cyc();
    expect_out("x3_after_set_clr", SEL_RS2_BUSY, 32'h1);
    expect_flags("x3", 1'b0, 1'b0);
    cyc();
    rf_bus.sb_clr    = 1'b1;
    rf_bus.sb_clr_rd = 5'd3;
    expect_out("x3_clr_nofwd", SEL_RS2_BUSY, 32'h1);
    cyc();
    expect_out("x3_drained", SEL_RS2_BUSY, 32'h0);

    // x0 scoreboard strobes have no effect
    cyc();
    rf_bus.rs1_addr  = 5'd0;
    rf_bus.sb_clr    = 1'b1;
    rf_bus.sb_clr_rd = 5'd0;
    expect_out("x0_sb_busy", SEL_RS1_BUSY, 32'h0);
    cyc();
    rf_bus.sb_set    = 1'b1;
    rf_bus.sb_set_rd = 5'd0;
    expect_flags("x0_clr", 1'b0, 1'b0);
    cyc();
    expect_flags("x0_set", 1'b0, 1'b0);
    expect_out("x0_sb_busy2", SEL_RS1_BUSY, 32'h0);

    // 6. overflow on x9
    rf_bus.rs1_addr = 5'd9;
    for (int i = 0; i < 4; i++) begin
      cyc();
      rf_bus.sb_set    = 1'b1;
      rf_bus.sb_set_rd = 5'd9;
      expect_out("x9_ovf_pre", SEL_OVF, 32'h0);
    end
    cyc();
    expect_out("x9_ovf", SEL_OVF, 32'h1);
    expect_out("x9_busy", SEL_RS1_BUSY, 32'h1);
    // count held at 3: three retires needed to drain
    for (int i = 0; i < 3; i++) begin
      cyc();
      rf_bus.sb_clr    = 1'b1;
      rf_bus.sb_clr_rd = 5'd9;
      expect_out("x9_drain_busy", SEL_RS1_BUSY, 32'h1);
    end
    cyc();
    expect_out("x9_drained", SEL_RS1_BUSY, 32'h0);
    expect_flags("x9_after", 1'b1, 1'b0);

    // underflow on x10
    cyc();
    rf_bus.rs2_addr  = 5'd10;
    rf_bus.sb_clr    = 1'b1;
    rf_bus.sb_clr_rd = 5'd10;
    expect_out("x10_unf_pre", SEL_UNF, 32'h0);
    expect_out("x10_busy", SEL_RS2_BUSY, 32'h0);
    cyc();
    expect_flags("x10_sticky", 1'b1, 1'b1);
    cyc();
    expect_flags("sticky_hold", 1'b1, 1'b1);

    // asynchronous reset mid-cycle
    cyc();
    rf_bus.sb_set    = 1'b1;
    rf_bus.sb_set_rd = 5'd12;
    cyc();
    rf_bus.rs1_addr = 5'd12;
    rf_bus.rs2_addr = 5'd5;
    expect_out("x12_busy_pre", SEL_RS1_BUSY, 32'h1);
    expect_out("x5_pre_rst", SEL_RS2_DATA, 32'hDEADBEEF);
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst_busy", SEL_RS1_BUSY, 32'h0);
    expect_out("async_rst_data", SEL_RS2_DATA, 32'h0);
    expect_flags("async_rst", 1'b0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_out("post_rst_busy", SEL_RS1_BUSY, 32'h0);
    expect_flags("post_rst", 1'b0, 1'b0);

    cyc();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
